// File: rtl/fix_word_packer.sv
// Packs a FIX byte stream little-end-first into DATA_WIDTH-bit RAM words and reports per-message summaries.
// Optional macro FIX_PACKER_CHECKSUM_EN adds the modulo-256 FIX checksum on msg_checksum_o.
module fix_word_packer #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_i,
  input  logic                  byte_last_i,
  output logic                  byte_ready_o,
  input  logic                  free_i,
  output logic                  write_o,
  output logic [ADDR_WIDTH-1:0] write_index_o,
  output logic [DATA_WIDTH-1:0] write_data_o,
  output logic                  msg_done_o,
  output logic [ADDR_WIDTH-1:0] msg_start_index_o,
  output logic [15:0]           msg_bytes_o,
  output logic [7:0]            msg_checksum_o
);

  localparam int BPW   = DATA_WIDTH / 8;
  localparam int POS_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int OCC_W = ADDR_WIDTH + 1;
  localparam logic [OCC_W-1:0] DEPTH    = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(BPW - 1);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t                  state_q, state_d;
  logic [POS_W-1:0]        pos_q, pos_d;
  logic [DATA_WIDTH-1:0]   word_q, word_d, word_fill;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [ADDR_WIDTH-1:0]   start_q, start_d;
  logic [OCC_W-1:0]        occ_q, occ_d, held;
  logic [15:0]             cnt_q, cnt_d, cnt_next;
  logic                    write_q, write_d;
  logic [ADDR_WIDTH-1:0]   write_index_q, write_index_d;
  logic [DATA_WIDTH-1:0]   write_data_q, write_data_d;
  logic                    msg_done_q, msg_done_d;
  logic [ADDR_WIDTH-1:0]   msg_start_index_q, msg_start_index_d;
  logic [15:0]             msg_bytes_q, msg_bytes_d;
  logic                    accept, complete, free_eff;

  // Held words include the one being written this cycle, so a completing byte
  // closes the door before the counter itself catches up.
  always_comb begin
    held         = occ_q + OCC_W'(write_q);
    byte_ready_o = (held < DEPTH);
    accept       = byte_valid_i && byte_ready_o;
    complete     = accept && ((pos_q == LAST_POS) || byte_last_i);
    free_eff     = free_i && (held != '0);
    occ_d        = held - OCC_W'(free_eff);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (accept) state_d = byte_last_i ? IDLE : ACTIVE;
  end

  always_comb begin
    word_fill         = word_q | (DATA_WIDTH'(byte_i) << {pos_q, 3'b000});
    cnt_next          = sat_inc16(cnt_q);
    pos_d             = pos_q;
    word_d            = word_q;
    idx_d             = idx_q;
    start_d           = start_q;
    cnt_d             = cnt_q;
    write_d           = 1'b0;
    write_index_d     = write_index_q;
    write_data_d      = write_data_q;
    msg_done_d        = 1'b0;
    msg_start_index_d = msg_start_index_q;
    msg_bytes_d       = msg_bytes_q;
    if (accept) begin
      cnt_d = cnt_next;
      if (state_q == IDLE) start_d = idx_q;
      if (complete) begin
        write_d       = 1'b1;
        write_index_d = idx_q;
        write_data_d  = word_fill;
        idx_d         = idx_q + 1'b1;
        pos_d         = '0;
        word_d        = '0;
      end else begin
        pos_d  = pos_q + 1'b1;
        word_d = word_fill;
      end
      if (byte_last_i) begin
        msg_done_d        = 1'b1;
        msg_start_index_d = (state_q == IDLE) ? idx_q : start_q;
        msg_bytes_d       = cnt_next;
        cnt_d             = '0;
      end
    end
  end

  // Write stage: everything below is visible one cycle after the accepting edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos_q             <= '0;
      word_q            <= '0;
      idx_q             <= '0;
      start_q           <= '0;
      occ_q             <= '0;
      cnt_q             <= '0;
      write_q           <= 1'b0;
      write_index_q     <= '0;
      write_data_q      <= '0;
      msg_done_q        <= 1'b0;
      msg_start_index_q <= '0;
      msg_bytes_q       <= '0;
    end else begin
      pos_q             <= pos_d;
      word_q            <= word_d;
      idx_q             <= idx_d;
      start_q           <= start_d;
      occ_q             <= occ_d;
      cnt_q             <= cnt_d;
      write_q           <= write_d;
      write_index_q     <= write_index_d;
      write_data_q      <= write_data_d;
      msg_done_q        <= msg_done_d;
      msg_start_index_q <= msg_start_index_d;
      msg_bytes_q       <= msg_bytes_d;
    end
  end

`ifdef FIX_PACKER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d, sum_next, checksum_q, checksum_d;

  always_comb begin
    sum_next   = sum_q + byte_i;
    sum_d      = sum_q;
    checksum_d = checksum_q;
    if (accept) begin
      sum_d = byte_last_i ? 8'h00 : sum_next;
      if (byte_last_i) checksum_d = sum_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q      <= 8'h00;
      checksum_q <= 8'h00;
    end else begin
      sum_q      <= sum_d;
      checksum_q <= checksum_d;
    end
  end

  assign msg_checksum_o = checksum_q;
`else
  assign msg_checksum_o = 8'h00;
`endif

  assign write_o           = write_q;
  assign write_index_o     = write_index_q;
  assign write_data_o      = write_data_q;
  assign msg_done_o        = msg_done_q;
  assign msg_start_index_o = msg_start_index_q;
  assign msg_bytes_o       = msg_bytes_q;

endmodule

// File: tb/tb_fix_word_packer.sv
// Randomized and directed bench for fix_word_packer against a message-level reference model.
module tb_fix_word_packer;
  localparam int DATA_WIDTH = 256;
  localparam int ADDR_WIDTH = 5;
  localparam int BPW        = DATA_WIDTH / 8;
  localparam int DEPTH      = 1 << ADDR_WIDTH;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  byte_valid_i = 1'b0;
  logic [7:0]            byte_i = 8'h00;
  logic                  byte_last_i = 1'b0;
  logic                  byte_ready_o;
  logic                  free_i = 1'b0;
  logic                  write_o;
  logic [ADDR_WIDTH-1:0] write_index_o;
  logic [DATA_WIDTH-1:0] write_data_o;
  logic                  msg_done_o;
  logic [ADDR_WIDTH-1:0] msg_start_index_o;
  logic [15:0]           msg_bytes_o;
  logic [7:0]            msg_checksum_o;

  fix_word_packer #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clk(clk), .rst(rst),
    .byte_valid_i(byte_valid_i), .byte_i(byte_i), .byte_last_i(byte_last_i),
    .byte_ready_o(byte_ready_o), .free_i(free_i),
    .write_o(write_o), .write_index_o(write_index_o), .write_data_o(write_data_o),
    .msg_done_o(msg_done_o), .msg_start_index_o(msg_start_index_o),
    .msg_bytes_o(msg_bytes_o), .msg_checksum_o(msg_checksum_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: words held downstream, next RAM slot, open message contents.
  int         m_stored;
  int         m_idx;
  bit         m_open;
  int         m_start;
  int         m_cnt;
  int         m_sum;
  logic [7:0] m_word[$];

  task automatic chk(input string tag, input logic [DATA_WIDTH-1:0] act,
                     input logic [DATA_WIDTH-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_clear();
    m_stored = 0;
    m_idx    = 0;
    m_open   = 0;
    m_start  = 0;
    m_cnt    = 0;
    m_sum    = 0;
    m_word.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    byte_valid_i = 1'b0;
    byte_last_i  = 1'b0;
    free_i       = 1'b0;
    rst          = 1'b0;
    #2;
    chk("rst_ready", byte_ready_o, 1);
    chk("rst_write", write_o, 0);
    chk("rst_done", msg_done_o, 0);
    chk("rst_index", write_index_o, 0);
    chk("rst_data", write_data_o, 0);
    chk("rst_start", msg_start_index_o, 0);
    chk("rst_bytes", msg_bytes_o, 0);
    chk("rst_sum", msg_checksum_o, 0);
    @(negedge clk);
    rst = 1'b1;
    model_clear();
  endtask

  task automatic cycle(input logic v, input logic [7:0] b, input logic l, input logic f);
    bit                    rdy, acc;
    bit                    e_wr, e_done;
    int                    e_idx, e_start, e_bytes;
    logic [7:0]            e_sum;
    logic [DATA_WIDTH-1:0] e_data;
    @(negedge clk);
    byte_valid_i = v;
    byte_i       = b;
    byte_last_i  = l;
    free_i       = f;
    rdy = (m_stored < DEPTH);
    chk("ready", byte_ready_o, rdy);
    acc    = v && rdy;
    e_wr   = 0;
    e_done = 0;
    e_idx  = 0;
    e_data = '0;
    e_start = 0;
    e_bytes = 0;
    e_sum   = 8'h00;
    if (f && m_stored > 0) m_stored--;
    if (acc) begin
      if (!m_open) begin
        m_start = m_idx;
        m_cnt   = 0;
        m_sum   = 0;
        m_open  = 1;
      end
      m_word.push_back(b);
      m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
      m_sum = (m_sum + b) % 256;
      if (m_word.size() == BPW || l) begin
        foreach (m_word[k]) e_data = e_data + (DATA_WIDTH'(m_word[k]) << (8 * k));
        e_wr  = 1;
        e_idx = m_idx;
        m_idx = (m_idx + 1) % DEPTH;
        m_word.delete();
        m_stored++;
      end
      if (l) begin
        e_done  = 1;
        e_start = m_start;
        e_bytes = m_cnt;
`ifdef FIX_PACKER_CHECKSUM_EN
        e_sum   = 8'(m_sum);
`endif
        m_open  = 0;
      end
    end
    @(posedge clk);
    #1;
    chk("write", write_o, e_wr);
    if (e_wr) begin
      chk("index", write_index_o, e_idx);
      chk("data", write_data_o, e_data);
    end
    chk("done", msg_done_o, e_done);
    if (e_done) begin
      chk("start", msg_start_index_o, e_start);
      chk("bytes", msg_bytes_o, e_bytes);
      chk("checksum", msg_checksum_o, e_sum);
    end
  endtask

  initial begin
    model_clear();
    do_reset();

    // 32-byte full word
    for (int i = 0; i < 32; i++) cycle(1, 8'(i), i == 31, 0);
    // 3-byte partial word
    cycle(1, 8'h38, 0, 0);
    cycle(1, 8'h3D, 0, 0);
    cycle(1, 8'h01, 1, 0);
    cycle(0, 8'h00, 0, 0);

    // reset mid-message, then a fresh message from index 0
    for (int i = 0; i < 10; i++) cycle(1, 8'($urandom), 0, 0);
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1, 8'($urandom), i == 3, 0);
    do_reset();

    // fill to DEPTH with one-byte messages, blocked offers, free, wrap
    for (int i = 0; i < 32; i++) cycle(1, 8'($urandom), 1, 0);
    chk("full_ready", byte_ready_o, 0);
    for (int i = 0; i < 3; i++) cycle(1, 8'($urandom), 1'($urandom), 0);
    cycle(0, 8'h00, 0, 1);
    cycle(1, 8'hA5, 1, 0);
    chk("wrap_index", write_index_o, 0);

    // drain to 5, free coinciding with write, drain to 0, free at 0, refill
    for (int i = 0; i < 27; i++) cycle(0, 8'h00, 0, 1);
    cycle(1, 8'h11, 1, 0);
    cycle(0, 8'h00, 0, 1);
    for (int i = 0; i < 5; i++) cycle(0, 8'h00, 0, 1);
    cycle(0, 8'h00, 0, 1);
    cycle(0, 8'h00, 0, 1);
    for (int i = 0; i < 32; i++) cycle(1, 8'($urandom), 1, 0);
    chk("refill_ready", byte_ready_o, 0);
    do_reset();

    // back-to-back 40-byte and 2-byte messages
    for (int i = 0; i < 40; i++) cycle(1, 8'($urandom), i == 39, 0);
    for (int i = 0; i < 2; i++) cycle(1, 8'($urandom), i == 1, 0);
    cycle(0, 8'h00, 0, 0);

    // randomized traffic with varying downstream pressure
    for (int blk = 0; blk < 8; blk++) begin
      int fprob = (blk % 4) * 30;
      for (int i = 0; i < 400; i++)
        cycle($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 19) == 0,
              $urandom_range(0, 99) < fprob);
      if (blk == 4) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
